// File: rtl/rtc_pkg.sv
// Shared types and constants for the BCD real-time clock and its 7-segment decode.
// Pure declarations; no state, no latency, no flow control.
package rtc_pkg;

    typedef logic [3:0] bcd_t;

    // Active-high segments, bit6=a .. bit0=g
    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam bcd_t UNITS_MAX          = 4'd9;
    localparam bcd_t SEC_TENS_MAX       = 4'd5;
    localparam bcd_t HR_TENS_MAX        = 4'd2;
    localparam bcd_t HR_UNITS_MAX_AT_20 = 4'd3;

    function automatic bcd_t bcd_inc(input bcd_t v, input bcd_t max);
        return (v == max) ? '0 : bcd_t'(v + 4'd1);
    endfunction

endpackage

// File: rtl/top_rtc_if.sv
// Bundle of the six 7-segment digit lines driven by the clock (seconds, minutes, hours).
// Plain wires; the driver is always ready, no backpressure.
interface top_rtc_if;

    logic [6:0] sl;
    logic [6:0] sm;
    logic [6:0] ml;
    logic [6:0] mm;
    logic [6:0] hl;
    logic [6:0] hm;

    modport master (output sl, sm, ml, mm, hl, hm);
    modport slave  (input  sl, sm, ml, mm, hl, hm);

endinterface

// File: rtl/seg7_decode.sv
// BCD digit to active-high 7-segment code; values 10..15 blank the digit.
// Purely combinational, zero latency, no flow control.
module seg7_decode
    import rtc_pkg::*;
(
    input  bcd_t       bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/top_rtc.sv
// 24-hour HH:MM:SS BCD clock with prescaler; advances once every TICKS_PER_SEC clk cycles.
// Outputs decode the registered digits combinationally (no added latency); free-running, no backpressure.
module top_rtc
    import rtc_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1
) (
    input  logic       rst,
    input  logic       clk,
    output logic [6:0] sl,
    output logic [6:0] sm,
    output logic [6:0] ml,
    output logic [6:0] mm,
    output logic [6:0] hl,
    output logic [6:0] hm
);

    localparam int              PW      = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0]   PRE_MAX = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] pre_q, pre_d;
    bcd_t s_l_q, s_l_d, s_m_q, s_m_d;
    bcd_t m_l_q, m_l_d, m_m_q, m_m_d;
    bcd_t h_l_q, h_l_d, h_m_q, h_m_d;

    logic tick;
    logic c_sl, c_sm, c_ml, c_mm;
    logic hr_wrap;

    always_comb begin
        tick  = (pre_q == PRE_MAX);
        pre_d = tick ? '0 : pre_q + 1'b1;

        // Carries ripple within one cycle so 23:59:59 -> 00:00:00 is a single edge
        c_sl = tick && (s_l_q == UNITS_MAX);
        c_sm = c_sl && (s_m_q == SEC_TENS_MAX);
        c_ml = c_sm && (m_l_q == UNITS_MAX);
        c_mm = c_ml && (m_m_q == SEC_TENS_MAX);

        s_l_d = tick ? bcd_inc(s_l_q, UNITS_MAX)    : s_l_q;
        s_m_d = c_sl ? bcd_inc(s_m_q, SEC_TENS_MAX) : s_m_q;
        m_l_d = c_sm ? bcd_inc(m_l_q, UNITS_MAX)    : m_l_q;
        m_m_d = c_ml ? bcd_inc(m_m_q, SEC_TENS_MAX) : m_m_q;

        hr_wrap = (h_m_q == HR_TENS_MAX) && (h_l_q == HR_UNITS_MAX_AT_20);
        h_l_d   = h_l_q;
        h_m_d   = h_m_q;
        if (c_mm) begin
            if (hr_wrap) begin
                h_l_d = '0;
                h_m_d = '0;
            end else if (h_l_q == UNITS_MAX) begin
                h_l_d = '0;
                h_m_d = bcd_t'(h_m_q + 4'd1);
            end else begin
                h_l_d = bcd_t'(h_l_q + 4'd1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
            s_l_q <= '0;
            s_m_q <= '0;
            m_l_q <= '0;
            m_m_q <= '0;
            h_l_q <= '0;
            h_m_q <= '0;
        end else begin
            pre_q <= pre_d;
            s_l_q <= s_l_d;
            s_m_q <= s_m_d;
            m_l_q <= m_l_d;
            m_m_q <= m_m_d;
            h_l_q <= h_l_d;
            h_m_q <= h_m_d;
        end
    end

    seg7_decode u_seg_sl (.bcd(s_l_q), .seg(sl));
    seg7_decode u_seg_sm (.bcd(s_m_q), .seg(sm));
    seg7_decode u_seg_ml (.bcd(m_l_q), .seg(ml));
    seg7_decode u_seg_mm (.bcd(m_m_q), .seg(mm));
    seg7_decode u_seg_hl (.bcd(h_l_q), .seg(hl));
    seg7_decode u_seg_hm (.bcd(h_m_q), .seg(hm));

endmodule

// File: tb/tb_top_rtc.sv
// Bench for top_rtc: one instance at 1 tick/s and one at 4 ticks/s share a clock,
// each checked against a time-of-day model derived from edges counted since reset.
module tb_top_rtc;

    localparam logic [41:0] ALL_ZERO = {6{7'h7E}};

    logic clk = 1'b0;
    logic rst1;
    logic rst4;

    always #5 clk = ~clk;

    top_rtc_if d1 ();
    top_rtc_if d4 ();

    top_rtc #(.TICKS_PER_SEC(1)) u_dut1 (
        .rst(rst1), .clk(clk),
        .sl(d1.sl), .sm(d1.sm), .ml(d1.ml), .mm(d1.mm), .hl(d1.hl), .hm(d1.hm)
    );

    top_rtc #(.TICKS_PER_SEC(4)) u_dut4 (
        .rst(rst4), .clk(clk),
        .sl(d4.sl), .sm(d4.sm), .ml(d4.ml), .mm(d4.mm), .hl(d4.hl), .hm(d4.hm)
    );

    logic [41:0] disp1;
    logic [41:0] disp4;
    assign disp1 = {d1.hm, d1.hl, d1.mm, d1.ml, d1.sm, d1.sl};
    assign disp4 = {d4.hm, d4.hl, d4.mm, d4.ml, d4.sm, d4.sl};

    logic [6:0] seg_tab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    int tests = 0;
    int fails = 0;
    int c1 = 0;   // edges since last reset, 1 tick/s instance
    int c4 = 0;   // edges since last reset, 4 ticks/s instance

    // Expected display after cyc edges out of reset at tps edges per second
    function automatic logic [41:0] exp_disp(input int cyc, input int tps);
        int s, h, m, sec;
        s   = (cyc / tps) % 86400;
        h   = s / 3600;
        m   = (s / 60) % 60;
        sec = s % 60;
        return {seg_tab[h / 10], seg_tab[h % 10], seg_tab[m / 10],
                seg_tab[m % 10], seg_tab[sec / 10], seg_tab[sec % 10]};
    endfunction

    function automatic bit is_checkpoint(input int cyc);
        int cps [12] = '{3599, 3600, 35999, 36000, 43199, 43200,
                         71999, 72000, 86399, 86400, 86401, 86404};
        for (int i = 0; i < 12; i++)
            if (cps[i] == cyc) return 1'b1;
        return 1'b0;
    endfunction

    // One rising edge, then park on the falling edge where outputs are sampled
    task automatic cycle();
        @(posedge clk);
        c1 = rst1 ? 0 : c1 + 1;
        c4 = rst4 ? 0 : c4 + 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst1 = 1'b1;
        rst4 = 1'b1;
        repeat (2) cycle();
        tests++;
        if (disp1 !== ALL_ZERO) begin
            fails++; $display("FAIL reset_dut1: got %h expected %h", disp1, ALL_ZERO);
        end
        tests++;
        if (disp4 !== ALL_ZERO) begin
            fails++; $display("FAIL reset_dut4: got %h expected %h", disp4, ALL_ZERO);
        end
        repeat (10) cycle();
        tests++;
        if (disp1 !== ALL_ZERO) begin
            fails++; $display("FAIL reset_hold_dut1: got %h expected %h", disp1, ALL_ZERO);
        end
        tests++;
        if (disp4 !== ALL_ZERO) begin
            fails++; $display("FAIL reset_hold_dut4: got %h expected %h", disp4, ALL_ZERO);
        end
    endtask

    task automatic test_seconds_minutes();
        rst1 = 1'b0;
        while (c1 < 605) begin
            cycle();
            tests++;
            if (disp1 !== exp_disp(c1, 1)) begin
                fails++;
                $display("FAIL count_dut1 edge %0d: got %h expected %h", c1, disp1, exp_disp(c1, 1));
            end
        end
        tests++;
        if (disp4 !== ALL_ZERO) begin
            fails++; $display("FAIL reset_long_dut4: got %h expected %h", disp4, ALL_ZERO);
        end
    endtask

    task automatic test_prescaler();
        rst4 = 1'b0;
        repeat (40) begin
            cycle();
            tests++;
            if (disp4 !== exp_disp(c4, 4)) begin
                fails++;
                $display("FAIL prescale_dut4 edge %0d: got %h expected %h", c4, disp4, exp_disp(c4, 4));
            end
        end
    endtask

    task automatic test_mid_reset4();
        int n;
        n = $urandom_range(200, 400);
        repeat (n) cycle();
        tests++;
        if (disp4 !== exp_disp(c4, 4)) begin
            fails++; $display("FAIL pre_abort_dut4: got %h expected %h", disp4, exp_disp(c4, 4));
        end
        rst4 = 1'b1;
        cycle();
        tests++;
        if (disp4 !== ALL_ZERO) begin
            fails++; $display("FAIL abort_dut4: got %h expected %h", disp4, ALL_ZERO);
        end
        rst4 = 1'b0;
        repeat (9) begin
            cycle();
            tests++;
            if (disp4 !== exp_disp(c4, 4)) begin
                fails++;
                $display("FAIL resume_dut4 edge %0d: got %h expected %h", c4, disp4, exp_disp(c4, 4));
            end
        end
    endtask

    task automatic test_day();
        while (c1 < 86405) begin
            cycle();
            if (is_checkpoint(c1) || $urandom_range(0, 1023) == 0) begin
                tests++;
                if (disp1 !== exp_disp(c1, 1)) begin
                    fails++;
                    $display("FAIL day_dut1 edge %0d: got %h expected %h", c1, disp1, exp_disp(c1, 1));
                end
            end
        end
        tests++;
        if (disp4 !== exp_disp(c4, 4)) begin
            fails++; $display("FAIL day_dut4: got %h expected %h", disp4, exp_disp(c4, 4));
        end
    endtask

    task automatic test_back_to_back();
        int n;
        n = $urandom_range(20, 60);
        repeat (n) cycle();
        rst1 = 1'b1;
        cycle();
        tests++;
        if (disp1 !== ALL_ZERO) begin
            fails++; $display("FAIL abort_dut1: got %h expected %h", disp1, ALL_ZERO);
        end
        rst1 = 1'b0;
        repeat (12) begin
            cycle();
            tests++;
            if (disp1 !== exp_disp(c1, 1)) begin
                fails++;
                $display("FAIL resume_dut1 edge %0d: got %h expected %h", c1, disp1, exp_disp(c1, 1));
            end
        end
    endtask

    initial begin
        rst1 = 1'b1;
        rst4 = 1'b1;
        test_reset();
        test_seconds_minutes();
        test_prescaler();
        test_mid_reset4();
        test_day();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
